sram_mem_responder: RTL and testbench

- Memory-stage responder that services the mem_read/mem_write requests decoded by the control unit and carried down the pipeline.
- Translates a 32-bit byte address into two 16-bit accesses on an external single-port SRAM.
- Holds the pipeline via ready until each access completes.
- Sits between the EXE/MEM pipeline register and the off-chip SRAM.

---
 rtl/sram_mem_responder.sv | 136 +++++++++++++
 tb/tb_sram_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_responder.sv
// Memory-stage responder: splits each 32-bit load/store into two 16-bit
// accesses (low half, then high half) on an external single-port SRAM.
module sram_mem_responder #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

  localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES);
  localparam logic [31:0] BASE     = 32'(ADDR_BASE);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [15:0] low_half_q, low_half_d;
  logic [31:0] read_data_q, read_data_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_dq_out_q, sram_dq_out_d;
  logic        sram_dq_oe_q, sram_dq_oe_d;
  logic        sram_we_n_q, sram_we_n_d;

  logic        req;
  logic [16:0] word;

  assign req  = mem_read | mem_write;
  // Out-of-range addresses wrap: the cast keeps only the low 17 word bits.
  assign word = 17'((address - BASE) >> 2);

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    low_half_d    = low_half_q;
    read_data_d   = read_data_q;
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = sram_dq_oe_q;
    sram_we_n_d   = sram_we_n_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d     = ST_LOW;
          cnt_d       = '0;
          write_d     = mem_write;
          sram_addr_d = {word, 1'b0};
          if (mem_write) begin
            sram_dq_out_d = write_data[15:0];
            sram_dq_oe_d  = 1'b1;
            sram_we_n_d   = 1'b0;
          end
        end
      end
      ST_LOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_HIGH;
          cnt_d       = '0;
          sram_addr_d = {word, 1'b1};
          if (write_q) sram_dq_out_d = write_data[31:16];
          else         low_half_d    = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = ST_DONE;
          sram_dq_oe_d = 1'b0;
          sram_we_n_d  = 1'b1;
          if (!write_q) read_data_d = {sram_dq_in, low_half_q};
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      low_half_q    <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      low_half_q    <= low_half_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

  // Freeze the pipeline from the request cycle until the DONE cycle.
  assign ready       = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench for sram_mem_responder: one instance with two wait states
// backed by a small SRAM model, one zero-wait instance for the short case.
module tb_sram_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        z_read, z_write;
  logic [31:0] z_address, z_write_data, z_read_data;
  logic        z_ready;
  logic [17:0] z_sram_addr;
  logic [15:0] z_dq_out;
  logic [15:0] z_dq_in;
  logic        z_dq_oe, z_we_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram_mem [0:63];

  always #5 clk = ~clk;

  sram_mem_responder #(.ADDR_BASE(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  sram_mem_responder #(.ADDR_BASE(1024), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .mem_read(z_read), .mem_write(z_write),
    .address(z_address), .write_data(z_write_data), .read_data(z_read_data),
    .ready(z_ready), .sram_addr(z_sram_addr), .sram_dq_out(z_dq_out),
    .sram_dq_oe(z_dq_oe), .sram_dq_in(z_dq_in), .sram_we_n(z_we_n)
  );

  // Asynchronous-read, synchronous-write SRAM model.
  assign sram_dq_in = sram_mem[sram_addr[5:0]];
  assign z_dq_in    = 16'h0000;
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on the two-wait-state instance, starting from IDLE with the
  // request already applied; returns in the DONE cycle.
  task automatic run_access(input string name, input logic is_write,
                            input logic [17:0] lo_addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd);
    for (int k = 1; k <= 6; k++) begin
      step();
      check({name, " ready low"}, 32'(ready), 32'd0);
      check({name, " addr"}, 32'(sram_addr), 32'(k <= 3 ? lo_addr : lo_addr + 18'd1));
      check({name, " we_n"}, 32'(sram_we_n), 32'(!is_write));
      check({name, " oe"}, 32'(sram_dq_oe), 32'(is_write));
      if (is_write)
        check({name, " dq_out"}, 32'(sram_dq_out), 32'(k <= 3 ? wdata[15:0] : wdata[31:16]));
    end
    step();
    check({name, " done ready"}, 32'(ready), 32'd1);
    check({name, " done we_n"}, 32'(sram_we_n), 32'd1);
    check({name, " done oe"}, 32'(sram_dq_oe), 32'd0);
    check({name, " done addr held"}, 32'(sram_addr), 32'(lo_addr + 18'd1));
    check({name, " read_data"}, read_data, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0000;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
    z_read = 1'b0; z_write = 1'b0; z_address = '0; z_write_data = '0;
    #12;
    check("reset ready", 32'(ready), 32'd1);
    check("reset read_data", read_data, 32'd0);
    check("reset addr", 32'(sram_addr), 32'd0);
    check("reset dq_out", 32'(sram_dq_out), 32'd0);
    check("reset oe", 32'(sram_dq_oe), 32'd0);
    check("reset we_n", 32'(sram_we_n), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Write 0xDEADBEEF to byte address 1028 -> SRAM halves 2 and 3.
    mem_write = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
    #1;
    check("wr idle ready", 32'(ready), 32'd0);
    run_access("wr", 1'b1, 18'd2, 32'hDEADBEEF, 32'd0);
    mem_write = 1'b0;
    step();
    check("wr idle after", 32'(ready), 32'd1);
    check("sram[2]", 32'(sram_mem[2]), 32'h0000BEEF);
    check("sram[3]", 32'(sram_mem[3]), 32'h0000DEAD);

    // Read it back.
    mem_read = 1'b1;
    run_access("rd", 1'b0, 18'd2, 32'd0, 32'hDEADBEEF);
    mem_read = 1'b0;
    step();
    check("rd hold", read_data, 32'hDEADBEEF);

    // Zero wait states: one cycle per half.
    z_write = 1'b1; z_address = 32'd1024; z_write_data = 32'h12345678;
    #1;
    check("w0 idle ready", 32'(z_ready), 32'd0);
    step();
    check("w0 lo ready", 32'(z_ready), 32'd0);
    check("w0 lo addr", 32'(z_sram_addr), 32'd0);
    check("w0 lo dq", 32'(z_dq_out), 32'h5678);
    check("w0 lo we_n", 32'(z_we_n), 32'd0);
    step();
    check("w0 hi ready", 32'(z_ready), 32'd0);
    check("w0 hi addr", 32'(z_sram_addr), 32'd1);
    check("w0 hi dq", 32'(z_dq_out), 32'h1234);
    step();
    check("w0 done ready", 32'(z_ready), 32'd1);
    check("w0 done we_n", 32'(z_we_n), 32'd1);
    z_write = 1'b0;

    // Reset during the HIGH phase of a read, then restart with the request held.
    mem_read = 1'b1; address = 32'd1028;
    for (int k = 0; k < 4; k++) step();
    check("rst pre addr", 32'(sram_addr), 32'd3);
    rst = 1'b1;
    #1;
    check("rst ready", 32'(ready), 32'd0);
    check("rst we_n", 32'(sram_we_n), 32'd1);
    check("rst read_data", read_data, 32'd0);
    check("rst addr", 32'(sram_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_access("rd restart", 1'b0, 18'd2, 32'd0, 32'hDEADBEEF);
    mem_read = 1'b0;
    step();

    // Both requests at once: the write wins, read_data is untouched.
    mem_read = 1'b1; mem_write = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
    run_access("both", 1'b1, 18'd4, 32'hCAFEF00D, 32'hDEADBEEF);

    // Back-to-back: read request already present in the write's DONE cycle.
    mem_write = 1'b0;
    step();
    check("b2b idle ready", 32'(ready), 32'd0);
    check("b2b idle we_n", 32'(sram_we_n), 32'd1);
    check("sram[4]", 32'(sram_mem[4]), 32'h0000F00D);
    check("sram[5]", 32'(sram_mem[5]), 32'h0000CAFE);
    run_access("b2b rd", 1'b0, 18'd4, 32'd0, 32'hCAFEF00D);
    mem_read = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
